// File: rtl/credit_pack.sv
// ============================================================================
// Module   : credit_pack
// Purpose  : Packs 16-bit stream words into 16-word lines and writes each line
//            plus a {size,line} descriptor, then queues the line index for the
//            consumer. Optional macro CREDIT_PACK_PAD_EN zeroes the unused
//            slots of a partial line on wr_b_data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_pack #(
    parameter int          OUT_DEPTH = 4,
    parameter logic [7:0]  LINE_INIT = 8'h00
) (
    input  logic         aclk,
    input  logic         reset_p,
    input  logic [15:0]  in_tdata,
    input  logic         in_tvalid,
    input  logic         in_tlast,
    output logic         in_tready,
    output logic [7:0]   wr_b_addr,
    output logic [255:0] wr_b_data,
    output logic         wr_b_write,
    output logic [7:0]   wr_a_addr,
    output logic [15:0]  wr_a_data,
    output logic         wr_a_write,
    output logic [7:0]   out_tdata,
    output logic         out_tvalid,
    input  logic         out_tready
);

    localparam int               c_AW   = $clog2(OUT_DEPTH);
    localparam int               c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0]  c_FULL = c_CW'(OUT_DEPTH);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [3:0]       r_wcnt;
    logic [3:0]       r_size;
    logic [255:0]     r_line;
    logic [7:0]       r_ptr;

    logic [7:0]       r_fifo [OUT_DEPTH];
    logic [c_AW-1:0]  r_wp;
    logic [c_AW-1:0]  r_rp;
    logic [c_CW-1:0]  r_cnt;

    logic             w_ready;
    logic             w_accept;
    logic             w_end;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [255:0]     w_line_out;

    // Reset gates every handshake/strobe so nothing leaks out while it is held.
    assign w_ready  = (r_state == S_FILL) && (r_cnt < c_FULL) && !reset_p;
    assign w_accept = in_tvalid && w_ready;
    assign w_end    = w_accept && (in_tlast || (r_wcnt == 4'hF));
    assign w_flush  = (r_state == S_FLUSH) && !reset_p;
    assign w_push   = w_flush;
    assign w_pop    = out_tvalid && out_tready;

    // ------------------------------------------------------------------
    // Two-process FSM
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (reset_p) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_end) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_FILL;
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word counter, size capture and line pointer
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (reset_p) begin
            r_wcnt <= 4'h0;
            r_size <= 4'h0;
            r_ptr  <= LINE_INIT;
        end else begin
            if (w_accept) begin
                if (w_end) begin
                    r_wcnt <= 4'h0;
                    // A full line wraps naturally to 4'h0, which is the 16-word encoding.
                    r_size <= r_wcnt + 4'h1;
                end else begin
                    r_wcnt <= r_wcnt + 4'h1;
                end
            end
            if (r_state == S_FLUSH) begin
                r_ptr <= r_ptr + 8'h01;
            end
        end
    end

    // Line storage needs no reset: a slot is always written before it is valid.
    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_line[{r_wcnt, 4'h0} +: 16] <= in_tdata;
        end
    end

    // ------------------------------------------------------------------
    // Output index FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (reset_p) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Input is held off at full, so a flush always finds a free entry.
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_fifo[r_wp] <= r_ptr;
        end
    end

    // ------------------------------------------------------------------
    // Line data presentation
    // ------------------------------------------------------------------
`ifdef CREDIT_PACK_PAD_EN
    generate
        if (1) begin : g_pad
            always_comb begin
                w_line_out = '0;
                for (int k = 0; k < 16; k++) begin
                    if ((r_size == 4'h0) || (4'(k) < r_size)) begin
                        w_line_out[k*16 +: 16] = r_line[k*16 +: 16];
                    end
                end
            end
        end
    endgenerate
`else
    generate
        if (1) begin : g_nopad
            assign w_line_out = r_line;
        end
    endgenerate
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_tready  = w_ready;
    assign wr_b_addr  = r_ptr;
    assign wr_b_data  = w_line_out;
    assign wr_b_write = w_flush;
    assign wr_a_addr  = r_ptr;
    assign wr_a_data  = {4'b0000, r_size, r_ptr};
    assign wr_a_write = w_flush;
    assign out_tdata  = r_fifo[r_rp];
    assign out_tvalid = (r_cnt != '0) && !reset_p;

endmodule

`default_nettype wire

// File: tb/tb_credit_pack.sv
// ============================================================================
// Module   : tb_credit_pack
// Purpose  : Scoreboard bench for credit_pack; expected lines/indices are
//            queued as words are accepted and compared when the DUT emits them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_credit_pack;

    logic         aclk = 1'b0;
    logic         reset_p;
    logic [15:0]  in_tdata;
    logic         in_tvalid;
    logic         in_tlast;
    logic         in_tready;
    logic [7:0]   wr_b_addr;
    logic [255:0] wr_b_data;
    logic         wr_b_write;
    logic [7:0]   wr_a_addr;
    logic [15:0]  wr_a_data;
    logic         wr_a_write;
    logic [7:0]   out_tdata;
    logic         out_tvalid;
    logic         out_tready;

    always #5 aclk = ~aclk;

    credit_pack #(
        .OUT_DEPTH (4),
        .LINE_INIT (8'h00)
    ) dut (
        .aclk       (aclk),
        .reset_p    (reset_p),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tready  (in_tready),
        .wr_b_addr  (wr_b_addr),
        .wr_b_data  (wr_b_data),
        .wr_b_write (wr_b_write),
        .wr_a_addr  (wr_a_addr),
        .wr_a_data  (wr_a_data),
        .wr_a_write (wr_a_write),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_acc_cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0]   addr;
        logic [15:0]  desc;
        logic [255:0] data;
        logic [255:0] mask;
    } line_t;

    line_t        exp_lines[$];
    logic [7:0]   exp_idx[$];
    logic [255:0] m_data;
    logic [255:0] m_mask;
    int           m_cnt = 0;
    logic [7:0]   m_ptr = 8'h00;

    function automatic void model_reset();
        m_cnt = 0;
        m_ptr = 8'h00;
        exp_lines.delete();
        exp_idx.delete();
    endfunction

    function automatic void model_accept(input logic [15:0] d, input logic last);
        line_t      l;
        logic [3:0] sz;
        if (m_cnt == 0) begin
            m_data = '0;
            m_mask = '0;
        end
        m_data[m_cnt*16 +: 16] = d;
        m_mask[m_cnt*16 +: 16] = 16'hFFFF;
        m_cnt++;
        if ((m_cnt == 16) || last) begin
            sz     = (m_cnt == 16) ? 4'h0 : 4'(m_cnt);
            l.addr = m_ptr;
            l.desc = {4'b0000, sz, m_ptr};
            l.data = m_data;
`ifdef CREDIT_PACK_PAD_EN
            l.mask = {256{1'b1}};
`else
            l.mask = m_mask;
`endif
            exp_lines.push_back(l);
            exp_idx.push_back(m_ptr);
            m_ptr = m_ptr + 8'h01;
            m_cnt = 0;
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge aclk) begin
        line_t l;
        if (wr_b_write || wr_a_write) begin
            chk("strobe_pair", {255'b0, wr_a_write}, {255'b0, wr_b_write});
            if (exp_lines.size() == 0) begin
                chk("unexpected_write", 256'(exp_lines.size()), 256'd1);
            end else begin
                l = exp_lines.pop_front();
                chk("wr_b_addr", {248'b0, wr_b_addr}, {248'b0, l.addr});
                chk("wr_a_addr", {248'b0, wr_a_addr}, {248'b0, l.addr});
                chk("wr_a_data", {240'b0, wr_a_data}, {240'b0, l.desc});
                chk("wr_b_data", wr_b_data & l.mask, l.data);
            end
        end
        if (out_tvalid && out_tready) begin
            if (exp_idx.size() == 0) begin
                chk("unexpected_idx", 256'(exp_idx.size()), 256'd1);
            end else begin
                chk("out_tdata", {248'b0, out_tdata}, {248'b0, exp_idx.pop_front()});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_word(input logic [15:0] d, input logic last);
        int  budget = 0;
        bit  done   = 0;
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        while (!done) begin
            @(negedge aclk);
            if (in_tready) begin
                done = 1;
            end else begin
                budget++;
                if (budget > 200) begin
                    chk("accept_timeout", 256'(budget), 256'd0);
                    in_tvalid = 1'b0;
                    in_tlast  = 1'b0;
                    return;
                end
            end
        end
        model_accept(d, last);
        last_acc_cyc = cyc;
        @(posedge aclk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_p = 1'b1;
        repeat (n) begin
            @(negedge aclk);
            chk("rst_in_tready",  {255'b0, in_tready},  256'd0);
            chk("rst_wr_write",   {255'b0, wr_b_write}, 256'd0);
            chk("rst_out_tvalid", {255'b0, out_tvalid}, 256'd0);
        end
        @(posedge aclk);
        #1;
        reset_p = 1'b0;
        model_reset();
    endtask

    initial begin
        int start_cyc;
        reset_p    = 1'b1;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;

        do_reset(3);
        @(negedge aclk);
        chk("ready_after_rst", {255'b0, in_tready}, 256'd1);
        @(posedge aclk);
        #1;

        // Full 16-word line, with latency probes
        for (int i = 0; i < 16; i++) send_word(16'h0100 + 16'(i), i == 15);
        chk("lat_wr_n1",  {255'b0, wr_b_write}, 256'd1);
        chk("lat_out_n1", {255'b0, out_tvalid}, 256'd0);
        @(posedge aclk);
        #1;
        chk("lat_out_n2", {255'b0, out_tvalid}, 256'd1);
        idle(2);

        // Short packet
        send_word(16'hAAAA, 1'b0);
        send_word(16'hBBBB, 1'b0);
        send_word(16'hCCCC, 1'b1);
        idle(3);

        // 40-word packet: split into 16+16+8, back to back
        for (int i = 0; i < 40; i++) begin
            send_word(16'h2000 + 16'(i), i == 39);
            if (i == 0) start_cyc = last_acc_cyc;
        end
        chk("throughput", 256'(last_acc_cyc - start_cyc), 256'd41);
        idle(4);

        // Output FIFO full back-pressure
        out_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(16'h3000 + 16'(i), 1'b1);
        idle(2);
        @(negedge aclk);
        chk("full_in_tready",  {255'b0, in_tready},  256'd0);
        chk("full_out_tvalid", {255'b0, out_tvalid}, 256'd1);
        fork
            send_word(16'h3004, 1'b1);
            begin
                repeat (4) @(negedge aclk);
                chk("blocked_in_tready", {255'b0, in_tready}, 256'd0);
                @(posedge aclk);
                #1;
                out_tready = 1'b1;
                @(posedge aclk);
                #1;
                out_tready = 1'b0;
            end
        join
        idle(3);
        out_tready = 1'b1;
        idle(8);

        // Reset in the middle of a line
        for (int i = 0; i < 7; i++) send_word(16'h4000 + 16'(i), 1'b0);
        do_reset(2);
        send_word(16'h4444, 1'b1);
        idle(4);

        // Reset landing on the flush cycle
        send_word(16'h5555, 1'b1);
        reset_p = 1'b1;
        void'(exp_lines.pop_back());
        void'(exp_idx.pop_back());
        do_reset(1);
        send_word(16'h5656, 1'b1);
        idle(4);

        // Pointer wrap 8'hFF -> 8'h00
        for (int i = 0; i < 258; i++) send_word(16'($urandom), 1'b1);
        idle(8);

        chk("lines_drained", 256'(exp_lines.size()), 256'd0);
        chk("idx_drained",   256'(exp_idx.size()),   256'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/credit_pack.md
CREDIT_PACK -- requirements
Module: credit_pack

Interface
REQ-001 The module SHALL have parameter OUT_DEPTH, default 4: depth of the output index FIFO, power of two, range 2..16.
REQ-002 The module SHALL have parameter LINE_INIT, default 8'h00: line/descriptor pointer value after reset.
REQ-003 aclk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_p  input  1  reset, synchronous, active-high.
REQ-005 in_tdata  input  16  packet word.
REQ-006 in_tvalid  input  1  word valid.
REQ-007 in_tlast  input  1  last word of packet.
REQ-008 in_tready  output  1  word accepted when in_tvalid & in_tready.
REQ-009 wr_b_addr  output  8  line memory write address.
REQ-010 wr_b_data  output  256  packed line, word k at bits [16k+15:16k].
REQ-011 wr_b_write  output  1  line memory write strobe.
REQ-012 wr_a_addr  output  8  descriptor memory write address.
REQ-013 wr_a_data  output  16  descriptor {4'b0, size[3:0], line[7:0]}.
REQ-014 wr_a_write  output  1  descriptor memory write strobe.
REQ-015 out_tdata  output  8  descriptor index of a completed line.
REQ-016 out_tvalid  output  1  index valid.
REQ-017 out_tready  input  1  index accepted when out_tvalid & out_tready.

Function
REQ-018 FSM SHALL have two states: FILL (accept words) and FLUSH (write line, one cycle).
REQ-019 in_tready SHALL be 1 only in FILL with output FIFO count < OUT_DEPTH.
REQ-020 Each accepted word SHALL be stored at slot wcnt (4-bit counter, 0..15) and wcnt SHALL increment.
REQ-021 Accepting a word with wcnt==15 or in_tlast==1 SHALL move FSM to FLUSH next cycle and clear wcnt.
REQ-022 In FLUSH, wr_b_write and wr_a_write SHALL both be 1 for exactly one cycle; wr_b_addr = wr_a_addr = ptr.
REQ-023 Descriptor size field SHALL be the word count of the line, 16 encoded as 4'h0, 1..15 as-is; line field = ptr.
REQ-024 In FLUSH, ptr SHALL be pushed into the output FIFO, then ptr SHALL increment modulo 256 (8'hFF wraps to 8'h00), FSM returns to FILL.
REQ-025 Latency: last word accepted in cycle N -> write strobes in N+1 -> out_tvalid in N+2 (if FIFO was empty).
REQ-026 Sustained throughput SHALL be 16 words per 17 cycles.
REQ-027 Output FIFO SHALL support push and pop in the same cycle; count unchanged.
REQ-028 Output FIFO full (count==OUT_DEPTH) SHALL only block input; a started line SHALL never be dropped.
REQ-029 wr_*_write SHALL be 0 outside FLUSH; wr_*_addr/data are don't-care when strobes are 0.
REQ-030 A packet longer than 16 words SHALL be split into consecutive lines, each with its own descriptor.

Reset
REQ-031 While reset_p==1: FSM=FILL, wcnt=0, ptr=LINE_INIT, output FIFO empty.
REQ-032 Outputs during and right after reset: in_tready=0 during reset, wr_b_write=0, wr_a_write=0, out_tvalid=0.
REQ-033 Reset mid-line SHALL discard the partial line with no memory write; reset in FLUSH SHALL suppress that write.

Configuration
REQ-034 Macro CREDIT_PACK_PAD_EN: when defined, unused slots of a partial line SHALL read 16'h0000 on wr_b_data.
REQ-035 Without CREDIT_PACK_PAD_EN, unused slots SHALL hold stale data from earlier lines (unspecified); all other behaviour is identical.

Verification
REQ-036 Reset, then 16 words 16'h0100..16'h010F with tlast on last -> one write, wr_b_addr=8'h00, wr_a_data=16'h0000, out_tdata=8'h00.
REQ-037 3-word packet 16'hAAAA,16'hBBBB,16'hCCCC with tlast -> wr_a_data=16'h0301; with PAD_EN, wr_b_data[255:48]=0.
REQ-038 40-word packet -> three descriptors, sizes 0,0,8 at ptr 0,1,2; out_tdata sequence 0,1,2.
REQ-039 out_tready=0, OUT_DEPTH=4, 5 one-word packets -> 4 indices queued, in_tready=0 until one pop, fifth completes afterwards.
REQ-040 LINE_INIT=8'hFE, three one-word packets -> ptrs 8'hFE, 8'hFF, 8'h00 (wrap).
REQ-041 reset_p asserted after 7 words of a line -> no write strobe, next line after reset written at LINE_INIT.
